sc_and_mult_ctrl: RTL and testbench

- Sequencer for a cascaded stochastic AND multiplier (N-input AND with enable).
- Accepts N binary operands and converts each to a bitstream with an LFSR-based stochastic number generator (SNG).
- Drives the AND block's inputs and enable for one full stream window, counts the ones on its output, and returns the binary product estimate with a START/DONE handshake.
- Sits between the neuron-level scheduler and each AND-based multiplier instance.

---
 rtl/sc_pkg.sv | 49 ++++
 rtl/sc_lfsr.sv | 45 ++++
 rtl/sc_and_mult_ctrl.sv | 145 ++++++++++++++
 tb/tb_sc_and_mult_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic AND multiplier sequencer:
// FSM state encoding, maximal-length LFSR tap masks and a rotate helper.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } sc_state_t;

    localparam int LFSR_MIN_W = 4;
    localparam int LFSR_MAX_W = 16;

    // Fibonacci feedback masks for a left-shifting LFSR; bit k-1 set means
    // register stage k feeds the XOR. Each entry gives a 2^W-1 period.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
        logic [LFSR_MAX_W-1:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    // Rotate the low 'width' bits of value left by 'amount' (0 <= amount < width).
    function automatic logic [LFSR_MAX_W-1:0] rotl(input logic [LFSR_MAX_W-1:0] value,
                                                    input int amount,
                                                    input int width);
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] v;
        mask = 16'((32'h1 << width) - 32'h1);
        v    = value & mask;
        return ((v << amount) | (v >> (width - amount))) & mask;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// W-bit Fibonacci LFSR used as the shared random source of the SNGs.
// LOAD restarts the sequence at SEED; STEP advances one state.
module sc_lfsr #(
    parameter int          W    = 8,
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LOAD,
    input  logic         STEP,
    output logic [W-1:0] Q
);
    import sc_pkg::*;

    localparam logic [LFSR_MAX_W-1:0] TAPS_FULL = lfsr_taps(W);
    localparam logic [W-1:0]          TAPS      = TAPS_FULL[W-1:0];
    localparam logic [W-1:0]          SEED_W    = SEED[W-1:0];

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;
    logic         feedback;

    // Next LFSR value: reload has priority over stepping, otherwise hold.
    always_comb begin
        feedback = ^(lfsr_q & TAPS);
        lfsr_d   = lfsr_q;
        if (LOAD) begin
            lfsr_d = SEED_W;
        end else if (STEP) begin
            lfsr_d = {lfsr_q[W-2:0], feedback};
        end
    end

    // State register; reset puts the generator back at the seed so it never sits at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q <= SEED_W;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign Q = lfsr_q;

endmodule

// File: rtl/sc_and_mult_ctrl.sv
// Sequencer for a cascaded stochastic AND multiplier. Latches N operands,
// streams one full LFSR period of stochastic bits into the external AND block,
// counts ones on its output and returns the count with a START/DONE handshake.
module sc_and_mult_ctrl #(
    parameter int          N    = 3,
    parameter int          W    = 8,
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [N*W-1:0] OPS,
    output logic           BUSY,
    output logic           DONE,
    output logic [W-1:0]   RESULT,
    output logic           AND_EN,
    output logic [N-1:0]   AND_IN,
    input  logic           AND_OUT
);
    import sc_pkg::*;

    // Value of the RUN cycle counter on the last of the 2^W-1 stream cycles.
    localparam logic [W-1:0] LAST_CYC = {{(W-1){1'b1}}, 1'b0};

    sc_state_t      state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   result_q, result_d;
    logic           and_en_q, and_en_d;
    logic [N-1:0]   and_in_q, and_in_d;
    logic [W-1:0]   ones_q, ones_d;
    logic [W-1:0]   cyc_q, cyc_d;
    logic [N*W-1:0] ops_q, ops_d;

    logic           lfsr_load;
    logic           lfsr_step;
    logic [W-1:0]   lfsr_val;
    logic [N-1:0]   sc_bits;

    sc_lfsr #(
        .W    (W),
        .SEED (SEED)
    ) u_lfsr (
        .CLK  (CLK),
        .RST  (RST),
        .LOAD (lfsr_load),
        .STEP (lfsr_step),
        .Q    (lfsr_val)
    );

    // One SNG comparator per operand; each sees the shared LFSR rotated by its index
    // so the streams are decorrelated without needing N separate generators.
    for (genvar g = 0; g < N; g++) begin : g_sng
        logic [W-1:0] rot_w;
        assign rot_w      = W'(rotl(16'(lfsr_val), g % W, W));
        assign sc_bits[g] = (ops_q[g*W +: W] >= rot_w);
    end

    // Next-state and next-output logic for the IDLE/FILL/RUN/FIN window sequence.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        and_en_d  = and_en_q;
        and_in_d  = and_in_q;
        ones_d    = ones_q;
        cyc_d     = cyc_q;
        ops_d     = ops_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    ops_d     = OPS;
                    lfsr_load = 1'b1;
                    ones_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                and_in_d  = sc_bits;
                lfsr_step = 1'b1;
                and_en_d  = 1'b1;
                cyc_d     = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (AND_OUT) begin
                    ones_d = ones_q + 1'b1;
                end
                and_in_d  = sc_bits;
                lfsr_step = 1'b1;
                if (cyc_q == LAST_CYC) begin
                    and_en_d = 1'b0;
                    state_d  = ST_FIN;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_FIN: begin
                result_d = ones_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any window and clears everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            and_en_q <= 1'b0;
            and_in_q <= '0;
            ones_q   <= '0;
            cyc_q    <= '0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            and_en_q <= and_en_d;
            and_in_q <= and_in_d;
            ones_q   <= ones_d;
            cyc_q    <= cyc_d;
            ops_q    <= ops_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign AND_EN = and_en_q;
    assign AND_IN = and_in_q;

endmodule

// File: tb/tb_sc_and_mult_ctrl.sv
// Self-checking bench for sc_and_mult_ctrl (N=3, W=8). A behavioural model
// lists the full LFSR period and counts, per state, whether every operand
// beats its rotated random number; windows are also checked for timing.
module tb_sc_and_mult_ctrl;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int L    = (1 << W) - 1;
    localparam int MAXC = 400;

    logic           CLK = 1'b0;
    logic           RST;
    logic           START;
    logic [N*W-1:0] OPS;
    logic           BUSY;
    logic           DONE;
    logic [W-1:0]   RESULT;
    logic           AND_EN;
    logic [N-1:0]   AND_IN;
    logic           AND_OUT;

    int compared   = 0;
    int mismatched = 0;
    int lfsr_seq [L];

    always #5 CLK = ~CLK;

    // The AND block under control: plain N-input AND gated by enable.
    assign AND_OUT = AND_EN & (&AND_IN);

    sc_and_mult_ctrl #(
        .N    (N),
        .W    (W),
        .SEED (32'd1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .OPS     (OPS),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .AND_EN  (AND_EN),
        .AND_IN  (AND_IN),
        .AND_OUT (AND_OUT)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int rotl8(input int v, input int r);
        return ((v << r) | (v >> (W - r))) & L;
    endfunction

    // Stochastic bit vector the controller should present for the k-th LFSR state.
    function automatic logic [N-1:0] model_bits(input logic [N*W-1:0] ops, input int k);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) begin
            b[i] = (int'(ops[i*W +: W]) >= rotl8(lfsr_seq[k], i % W));
        end
        return b;
    endfunction

    function automatic int model_result(input logic [N*W-1:0] ops);
        int cnt = 0;
        for (int k = 0; k < L; k++) begin
            if (&model_bits(ops, k)) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [N*W-1:0] rand_ops();
        logic [N*W-1:0] o;
        for (int i = 0; i < N; i++) begin
            o[i*W +: W] = W'($urandom_range(0, L));
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Follows a window starting at the sample just after the accepting edge (c=0).
    task automatic observeWindow(input logic [N*W-1:0] ops, input bit disturb, input bit hold,
                                 output int done_c, output int en_cycles,
                                 output int busy_cycles, output int in_errs);
        done_c      = -1;
        en_cycles   = 0;
        busy_cycles = 0;
        in_errs     = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            if (c == 0 && !hold) START = 1'b0;
            if (disturb && c == 50) begin
                START = 1'b1;
                OPS   = ~ops;
            end
            if (disturb && c == 53) START = 1'b0;
            if (BUSY) busy_cycles++;
            if (AND_EN) begin
                en_cycles++;
                if (c < 1 || c > L) in_errs++;
                else if (AND_IN !== model_bits(ops, c - 1)) in_errs++;
            end
            if (DONE) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [N*W-1:0] ops, input bit disturb, input bit hold,
                                 output int done_c, output int en_cycles,
                                 output int busy_cycles, output int in_errs);
        @(posedge CLK);
        #1;
        OPS   = ops;
        START = 1'b1;
        @(posedge CLK);
        #1;
        observeWindow(ops, disturb, hold, done_c, en_cycles, busy_cycles, in_errs);
    endtask

    task automatic runAndCheck(input string tag, input logic [N*W-1:0] ops,
                               input bit disturb, input int spec_expect);
        int done_c, en_c, busy_c, errs;
        applyStimulus(ops, disturb, 1'b0, done_c, en_c, busy_c, errs);
        checkOutput({tag, "_done_cycle"}, done_c, L + 2);
        checkOutput({tag, "_result_model"}, int'(RESULT), model_result(ops));
        if (spec_expect >= 0) checkOutput({tag, "_result_spec"}, int'(RESULT), spec_expect);
        checkOutput({tag, "_and_en_cycles"}, en_c, L);
        checkOutput({tag, "_busy_cycles"}, busy_c, L + 2);
        checkOutput({tag, "_and_in_seq_errs"}, errs, 0);
        @(posedge CLK);
        #1;
        checkOutput({tag, "_done_one_cycle"}, int'(DONE), 0);
    endtask

    initial begin
        int s, fb, highs, done_c, en_c, busy_c, errs;
        logic [N*W-1:0] ops_a, ops_b;

        s = 1;
        for (int k = 0; k < L; k++) begin
            lfsr_seq[k] = s;
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = ((s << 1) | fb) & L;
        end

        RST   = 1'b1;
        START = 1'b0;
        OPS   = '0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_outputs", int'({BUSY, DONE, AND_EN, AND_IN, RESULT}), 0);
        RST = 1'b0;
        highs = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            if (BUSY || DONE || AND_EN) highs++;
        end
        checkOutput("idle_no_activity", highs, 0);

        runAndCheck("pass", {8'd255, 8'd255, 8'd128}, 1'b0, 128);
        runAndCheck("zero_op", {8'd255, 8'd0, 8'd255}, 1'b0, 0);
        runAndCheck("all_ones", {8'd255, 8'd255, 8'd255}, 1'b0, L);
        runAndCheck("busy_prot", {8'd255, 8'd255, 8'd200}, 1'b1, 200);

        // Abort at RUN cycle 100 with asynchronous reset.
        @(posedge CLK);
        #1;
        OPS   = rand_ops();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (101) @(posedge CLK);
        #1;
        checkOutput("rst_mid_busy_before", int'(BUSY), 1);
        RST = 1'b1;
        #1;
        checkOutput("rst_mid_outputs", int'({BUSY, DONE, AND_EN, AND_IN, RESULT}), 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        highs = 0;
        repeat (300) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) highs++;
        end
        checkOutput("rst_no_done", highs, 0);
        runAndCheck("after_rst", {8'd37, 8'd250, 8'd190}, 1'b0, -1);

        runAndCheck("accuracy", {8'd128, 8'd128, 8'd128}, 1'b0, -1);
        checkOutput("accuracy_within_16",
                    (int'(RESULT) >= 16 && int'(RESULT) <= 48) ? 1 : 0, 1);

        for (int r = 0; r < 4; r++) begin
            runAndCheck($sformatf("random%0d", r), rand_ops(), 1'b0, -1);
        end

        // START held across FIN: ignored on FIN, accepted one IDLE cycle later.
        ops_a = rand_ops();
        ops_b = rand_ops();
        applyStimulus(ops_a, 1'b0, 1'b1, done_c, en_c, busy_c, errs);
        checkOutput("b2b_a_done_cycle", done_c, L + 2);
        checkOutput("b2b_a_result", int'(RESULT), model_result(ops_a));
        checkOutput("b2b_fin_start_ignored", int'(BUSY), 0);
        OPS = ops_b;
        @(posedge CLK);
        #1;
        checkOutput("b2b_accept_busy", int'(BUSY), 1);
        observeWindow(ops_b, 1'b0, 1'b0, done_c, en_c, busy_c, errs);
        checkOutput("b2b_b_done_cycle", done_c, L + 2);
        checkOutput("b2b_b_result", int'(RESULT), model_result(ops_b));
        checkOutput("b2b_b_and_in_seq_errs", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
